// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_pkg
//  Purpose  : Shared constants for the sequential ALU and the test-sequence
//             controller that feeds it: opcode values, FSM state encoding
//             and the default datapath width.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

   // Default operand / result width
   localparam int DEFAULT_WIDTH = 7;

   // Opcodes (also driven by the controller)
   localparam logic OP_NOT = 1'b0;
   localparam logic OP_SHR = 1'b1;

   // FSM state encoding
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

endpackage : seq_alu_pkg
`default_nettype wire

// File: rtl/shr_barrel.sv
`default_nettype none
// ============================================================================
//  Module   : shr_barrel
//  Purpose  : Single-cycle logical right shift with saturation. A shift
//             amount of WIDTH or more yields zero.
//  Ports    : A  - operand
//             n  - shift amount (already saturated by the caller is fine)
//             Y  - A >> n, zero filled from the MSB
//  Config   : Only compiled when SEQ_ALU_FAST_SHR_EN is defined; the default
//             build uses the iterative shifter inside seq_alu instead.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef SEQ_ALU_FAST_SHR_EN
module shr_barrel #(
   parameter int WIDTH = 7,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] A,
   input  logic [CW-1:0]    n,
   output logic [WIDTH-1:0] Y
);

   assign Y = (n >= CW'(WIDTH)) ? '0 : (A >> n);

endmodule : shr_barrel
`endif
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Sequential two-operation ALU (NOT / logical shift right).
//             NOT finishes in one cycle; SHR shifts one bit per clock
//             unless the barrel shifter option is compiled in. The result
//             and zero flag are registered and offered through a
//             valid/ready handshake.
//  Ports    : clk, reset (async, active high)
//             A, B, OP, in_valid, in_ready  - operation input handshake
//             Y, Z, out_valid, out_ready    - result output handshake
//  Config   : SEQ_ALU_FAST_SHR_EN - single-cycle barrel SHR (shr_barrel),
//             SHIFT state is then never entered.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             OP,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Y,
   output logic             Z,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int c_CNT_W = $clog2(WIDTH + 1);

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [WIDTH-1:0]   r_y;
   logic               r_z;
   logic [c_CNT_W-1:0] r_cnt;

   logic [c_CNT_W-1:0] w_n;          // saturated shift amount
   logic [WIDTH-1:0]   w_shr_y;      // value loaded into Y on an SHR accept
   logic               w_shr_done;   // SHR completes at the accept edge
   logic [WIDTH-1:0]   w_load_y;
   logic               w_load_done;

   // B below WIDTH always fits in the counter, so truncation is lossless
   assign w_n = (B >= WIDTH'(WIDTH)) ? c_CNT_W'(WIDTH) : c_CNT_W'(B);

`ifdef SEQ_ALU_FAST_SHR_EN
   shr_barrel #(
      .WIDTH (WIDTH),
      .CW    (c_CNT_W)
   ) u_shr_barrel (
      .A (A),
      .n (w_n),
      .Y (w_shr_y)
   );
   assign w_shr_done = 1'b1;
`else
   // Iterative path: load A unchanged, shift it in SHIFT
   assign w_shr_y    = A;
   assign w_shr_done = (w_n == '0);
`endif

   assign w_load_y    = (OP == OP_NOT) ? ~A : w_shr_y;
   assign w_load_done = (OP == OP_NOT) || w_shr_done;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next_state = w_load_done ? DONE : SHIFT;
         SHIFT:   if (r_cnt == c_CNT_W'(1)) w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   // ------------------------------------------------------------------
   // Datapath: result, zero flag and shift counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_y   <= '0;
         r_z   <= 1'b0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_y <= w_load_y;
                  if (w_load_done) r_z   <= (w_load_y == '0);
                  else             r_cnt <= w_n;
               end
            end
            SHIFT: begin
               r_y   <= r_y >> 1;
               r_cnt <= r_cnt - c_CNT_W'(1);
               // Last step: flag reflects the value being written now
               if (r_cnt == c_CNT_W'(1)) r_z <= ((r_y >> 1) == '0);
            end
            default: ;
         endcase
      end
   end

   assign Y = r_y;
   assign Z = r_z;

endmodule : seq_alu
`default_nettype wire
